// File: rtl/falu_arbiter_if.sv
// Request/response bus between NREQ FALU requesters and falu_arbiter.
// master = requester side, slave = arbiter side.
interface falu_arbiter_if #(
  parameter int unsigned NREQ = 2,
  parameter int unsigned IDW  = 1
);
  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_ready;
  logic [4*NREQ-1:0]  req_op;
  logic [32*NREQ-1:0] req_a;
  logic [32*NREQ-1:0] req_b;
  logic               rsp_valid;
  logic               rsp_ready;
  logic [IDW-1:0]     rsp_id;
  logic [31:0]        rsp_result;
  logic [2:0]         rsp_flags;
  logic               rsp_timeout;

  modport master (
    output req_valid, req_op, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_result, rsp_flags, rsp_timeout
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_result, rsp_flags, rsp_timeout
  );
endinterface

// File: rtl/falu_arbiter.sv
// Round-robin arbiter sharing one FALU between NREQ requesters.
// One op in flight: IDLE (grant/accept) -> BUSY (FALU running) -> RESP.
// Illegal option codes (0, >9) bypass the FALU and respond with flags 3'b100.
// Optional watchdog: define FALU_ARB_WDOG_EN to abort BUSY after WDOG_CYCLES.
module falu_arbiter #(
  parameter int unsigned NREQ        = 2,
  parameter int unsigned IDW         = (NREQ > 1) ? $clog2(NREQ) : 1,
  parameter int unsigned WDOG_CYCLES = 64
) (
  input  logic          clk,
  input  logic          rst,
  falu_arbiter_if.slave bus,
  output logic [3:0]    falu_option,
  output logic [31:0]   falu_a,
  output logic [31:0]   falu_b,
  output logic          falu_flush,
  input  logic [31:0]   falu_result,
  input  logic          falu_exc,
  input  logic          falu_ovf,
  input  logic          falu_unf,
  input  logic          falu_done
);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t         state, state_nxt;
  logic [IDW-1:0] rr_ptr, id_q, grant_id, cand, id_nxt_ptr;
  logic           grant_found, accept, op_legal, wdog_hit;
  logic [3:0]     op_q;
  logic [31:0]    a_q, b_q, result_q;
  logic [2:0]     flags_q;
  logic           timeout_q;

  logic [3:0]     op_arr [NREQ];
  logic [31:0]    a_arr  [NREQ];
  logic [31:0]    b_arr  [NREQ];

  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign op_arr[g] = bus.req_op[g*4 +: 4];
    assign a_arr[g]  = bus.req_a[g*32 +: 32];
    assign b_arr[g]  = bus.req_b[g*32 +: 32];
  end

  // Grant: first valid requester at or after rr_ptr, wrapping modulo NREQ.
  always_comb begin
    grant_found = 1'b0;
    grant_id    = '0;
    cand        = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      cand = IDW'((32'(rr_ptr) + i) % NREQ);
      if (!grant_found && bus.req_valid[cand]) begin
        grant_found = 1'b1;
        grant_id    = cand;
      end
    end
  end

  assign accept     = (state == IDLE) && grant_found;
  assign op_legal   = (op_arr[grant_id] != 4'd0) && (op_arr[grant_id] <= 4'd9);
  assign id_nxt_ptr = (id_q == IDW'(NREQ - 1)) ? '0 : id_q + 1'b1;

`ifdef FALU_ARB_WDOG_EN
  localparam int unsigned WDW = $clog2(WDOG_CYCLES + 1);
  logic [WDW-1:0] wd_cnt;

  assign wdog_hit = (state == BUSY) && !falu_done && (wd_cnt == WDW'(WDOG_CYCLES - 1));

  // Watchdog: counts BUSY cycles, cleared when an op is accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                 wd_cnt <= '0;
    else if (accept)         wd_cnt <= '0;
    else if (state == BUSY)  wd_cnt <= wd_cnt + 1'b1;
  end
`else
  assign wdog_hit = 1'b0;
`endif

  assign falu_flush = wdog_hit;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state and request-side ready.
  always_comb begin
    state_nxt     = state;
    bus.req_ready = '0;
    case (state)
      IDLE: if (grant_found) begin
        bus.req_ready[grant_id] = 1'b1;
        state_nxt = op_legal ? BUSY : RESP;
      end
      BUSY: if (falu_done || wdog_hit) state_nxt = RESP;
      RESP: if (bus.rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Operand latch, result capture and round-robin pointer update.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr    <= '0;
      id_q      <= '0;
      op_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      result_q  <= '0;
      flags_q   <= '0;
      timeout_q <= 1'b0;
    end else begin
      if (accept) begin
        op_q      <= op_arr[grant_id];
        a_q       <= a_arr[grant_id];
        b_q       <= b_arr[grant_id];
        id_q      <= grant_id;
        timeout_q <= 1'b0;
        if (!op_legal) begin
          result_q <= '0;
          flags_q  <= 3'b100;
        end
      end
      if (state == BUSY) begin
        if (falu_done) begin
          result_q <= falu_result;
          flags_q  <= {falu_exc, falu_ovf, falu_unf};
        end else if (wdog_hit) begin
          result_q  <= 32'h7FC0_0000;
          flags_q   <= 3'b100;
          timeout_q <= 1'b1;
        end
      end
      if ((state == RESP) && bus.rsp_ready) rr_ptr <= id_nxt_ptr;
    end
  end

  assign bus.rsp_valid   = (state == RESP);
  assign bus.rsp_id      = id_q;
  assign bus.rsp_result  = result_q;
  assign bus.rsp_flags   = flags_q;
  assign bus.rsp_timeout = timeout_q;

  assign falu_option = (state == BUSY) ? op_q : '0;
  assign falu_a      = (state == BUSY) ? a_q  : '0;
  assign falu_b      = (state == BUSY) ? b_q  : '0;

endmodule
